// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundle of every bus signal around dmem_arbiter: the two requester ports,
//   the single-port RAM pins and the busy flag.
//   Parameters: ADDR_W (RAM word-address width), DATA_W (data width).
//   Modports:
//     slave  - the arbiter: takes requests and ram_dataOut, drives grants,
//              read returns, RAM pins and busy.
//     master - the environment around it (requesters and RAM model).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_wen;
  logic              p0_lock;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_wen;
  logic              p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  logic              busy;

  modport slave (
    input  p0_req, p0_wen, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_wen, p1_lock, p1_addr, p1_wdata,
    input  ram_dataOut,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output ram_wEn, ram_addr, ram_dataIn,
    output busy
  );

  modport master (
    output p0_req, p0_wen, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_wen, p1_lock, p1_addr, p1_wdata,
    output ram_dataOut,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  ram_wEn, ram_addr, ram_dataIn,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data RAM between the CPU data port (port 0) and a
//   secondary peripheral master (port 1). At most one access is granted per
//   cycle; grants are combinational, read data returns one cycle after the
//   granting edge. A granted port may keep ownership for the next cycle by
//   holding lock, bounded by LOCK_MAX consecutive locked grants whenever the
//   peer is waiting.
//
//   Parameters: ADDR_W (RAM word address width), DATA_W (data width),
//               LOCK_MAX (1..15, max consecutive locked grants while the peer waits)
//   Ports:      clock  - system clock, rising edge
//               reset  - asynchronous, active-high
//               bus    - dmem_arbiter_if.slave (requesters, RAM pins, busy)
//
//   Build option: DMEM_ARB_ROUND_ROBIN_EN
//     defined   - contention goes to the port that was not granted last
//     undefined - contention always goes to port 0 (fixed priority)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no locked sequence open; plain arbitration
//   OWN0  | port 0 holds a lock; served first while it keeps requesting
//   OWN1  | port 1 holds a lock; served first while it keeps requesting
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

  own_t              own_q, own_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic              rv_valid_q, rv_valid_d;
  logic              rv_port_q, rv_port_d;

  logic              owner_on;
  logic              owner_is1;
  logic              owner_req;
  logic              peer_req;
  logic              lock_expired;
  logic              gnt_any;
  logic              gnt_sel;
  logic              sel_wen;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              p0_rv;
  logic              p1_rv;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Only the round-robin policy needs to remember who went last.
  logic last_q, last_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      own_q      <= IDLE;
      lock_cnt_q <= 4'd0;
      rv_valid_q <= 1'b0;
      rv_port_q  <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      own_q      <= own_d;
      lock_cnt_q <= lock_cnt_d;
      rv_valid_q <= rv_valid_d;
      rv_port_q  <= rv_port_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  always_comb begin
    gnt_any    = 1'b0;
    gnt_sel    = 1'b0;
    own_d      = IDLE;
    lock_cnt_d = 4'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif

    owner_on     = (own_q != IDLE);
    owner_is1    = (own_q == OWN1);
    owner_req    = owner_is1 ? bus.p1_req : bus.p0_req;
    peer_req     = owner_is1 ? bus.p0_req : bus.p1_req;
    // lock_cnt saturates at LOCK_MAX, so >= and == agree; >= keeps the
    // check safe if a lock ran on unchallenged past the limit.
    lock_expired = (lock_cnt_q >= LOCK_LIM) && peer_req;

    if (!reset) begin
      if (owner_on && owner_req) begin
        // An expired lock hands this cycle to the waiting peer, in either
        // policy, so neither port can be starved by the other's lock.
        gnt_any = 1'b1;
        gnt_sel = lock_expired ? !owner_is1 : owner_is1;
      end else if (bus.p0_req && bus.p1_req) begin
        gnt_any = 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        gnt_sel = !last_q;
`else
        gnt_sel = 1'b0;
`endif
      end else if (bus.p0_req || bus.p1_req) begin
        gnt_any = 1'b1;
        gnt_sel = bus.p1_req;
      end
    end

    sel_wen   = gnt_sel ? bus.p1_wen   : bus.p0_wen;
    sel_lock  = gnt_sel ? bus.p1_lock  : bus.p0_lock;
    sel_addr  = gnt_sel ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt_sel ? bus.p1_wdata : bus.p0_wdata;

    if (gnt_any && sel_lock) begin
      own_d = gnt_sel ? OWN1 : OWN0;
      if (own_d == own_q) begin
        lock_cnt_d = (lock_cnt_q >= LOCK_LIM) ? lock_cnt_q : lock_cnt_q + 4'd1;
      end else begin
        lock_cnt_d = 4'd1;
      end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (gnt_any) begin
      last_d = gnt_sel;
    end
`endif

    rv_valid_d = gnt_any && !sel_wen;
    rv_port_d  = gnt_sel;
  end

  // RAM pins are forced to zero when nobody is granted so a stray address or
  // write data never reaches the macro.
  assign bus.ram_wEn    = gnt_any && sel_wen;
  assign bus.ram_addr   = gnt_any ? sel_addr  : '0;
  assign bus.ram_dataIn = gnt_any ? sel_wdata : '0;

  assign bus.p0_gnt = gnt_any && !gnt_sel;
  assign bus.p1_gnt = gnt_any &&  gnt_sel;

  assign p0_rv = rv_valid_q && !rv_port_q;
  assign p1_rv = rv_valid_q &&  rv_port_q;

  assign bus.p0_rvalid = p0_rv;
  assign bus.p1_rvalid = p1_rv;
  assign bus.p0_rdata  = p0_rv ? bus.ram_dataOut : '0;
  assign bus.p1_rdata  = p1_rv ? bus.ram_dataOut : '0;

  assign bus.busy = owner_on;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios followed by randomized traffic on dmem_arbiter. A
//   behavioural model (owner / consecutive-run count / last winner plus a
//   shadow memory) predicts grants and RAM pins each cycle and queues the
//   expected read returns; an independent monitor pops and compares them
//   whenever a read return is due.
module tb_dmem_arbiter;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int LOCK_MAX    = 4;
  localparam int RAND_CYCLES = 600;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam int RR_EN = 1;
`else
  localparam int RR_EN = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  always @(posedge clock) begin
    if (bus.ram_wEn) ram[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= ram[bus.ram_addr];
  end

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  int m_owner;
  int m_run;
  int m_last;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
  endfunction

  function automatic int model_pick(input logic [1:0] r);
    if (m_owner >= 0 && r[m_owner]) begin
      if (m_run >= LOCK_MAX && r[1-m_owner]) return 1 - m_owner;
      return m_owner;
    end
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    if (r == 2'b11) return (RR_EN != 0) ? 1 - m_last : 0;
    return -1;
  endfunction

  // Called just after a falling edge: applies one cycle of requests, checks
  // grant and RAM pins against the model, then advances to the next falling edge.
  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                       output int gm, output int gd);
    logic              ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    bus.p0_req = r[0]; bus.p0_wen = w[0]; bus.p0_lock = l[0]; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r[1]; bus.p1_wen = w[1]; bus.p1_lock = l[1]; bus.p1_addr = a1; bus.p1_wdata = d1;
    #2;
    gm = model_pick(r);
    gd = bus.p0_gnt ? 0 : (bus.p1_gnt ? 1 : -1);
    chk("gnt", {bus.p1_gnt, bus.p0_gnt}, (gm < 0) ? 0 : ((gm == 0) ? 1 : 2));
    ew = 1'b0; ea = '0; ed = '0;
    if (gm == 0) begin ew = w[0]; ea = a0; ed = d0; end
    if (gm == 1) begin ew = w[1]; ea = a1; ed = d1; end
    chk("ram_wEn", bus.ram_wEn, ew);
    chk("ram_addr", bus.ram_addr, ea);
    chk("ram_dataIn", bus.ram_dataIn, ed);
    if (gm >= 0) begin
      if (ew) ref_mem[ea] = ed;
      else exp_q.push_back('{port: gm, data: ref_mem[ea]});
      m_last = gm;
      if (l[gm]) begin
        m_run   = (m_owner == gm) ? m_run + 1 : 1;
        m_owner = gm;
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
    end else begin
      m_owner = -1;
      m_run   = 0;
    end
    @(negedge clock);
    chk("busy", bus.busy, m_owner >= 0);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    bus.p0_req = 1'b1; bus.p0_wen = 1'b1; bus.p0_lock = 1'b1; bus.p0_addr = 12'h005; bus.p0_wdata = 32'hBAD0;
    bus.p1_req = 1'b1; bus.p1_wen = 1'b1; bus.p1_lock = 1'b1; bus.p1_addr = 12'h006; bus.p1_wdata = 32'hBAD1;
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk("rst_gnt", {bus.p1_gnt, bus.p0_gnt}, 0);
      chk("rst_ram_wEn", bus.ram_wEn, 0);
      chk("rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
      chk("rst_rdata", bus.p0_rdata, 0);
      chk("rst_busy", bus.busy, 0);
      @(negedge clock);
    end
    bus.p0_req = 1'b0; bus.p0_wen = 1'b0; bus.p0_lock = 1'b0;
    bus.p1_req = 1'b0; bus.p1_wen = 1'b0; bus.p1_lock = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    rd_exp_t e;
    @(negedge clock);
    forever begin
      @(posedge clock);
      #1;
      if (reset || exp_q.size() == 0) begin
        chk("rvalid_idle", {bus.p1_rvalid, bus.p0_rvalid}, 0);
        chk("rdata_idle", {bus.p1_rdata, bus.p0_rdata}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid", {bus.p1_rvalid, bus.p0_rvalid}, (e.port == 1) ? 2 : 1);
        chk("rdata", (e.port == 1) ? bus.p1_rdata : bus.p0_rdata, e.data);
        chk("rdata_other", (e.port == 1) ? bus.p0_rdata : bus.p1_rdata, 0);
      end
    end
  end

  initial begin
    int gm, gd;
    logic [1:0]        pv, pw, pl;
    logic [ADDR_W-1:0] pa [2];
    logic [DATA_W-1:0] pd [2];

    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i]     = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      ref_mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
    end
    ram[12'h010]     = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    bus.p0_req = 1'b0; bus.p0_wen = 1'b0; bus.p0_lock = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_wen = 1'b0; bus.p1_lock = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    model_reset();
    @(negedge clock);
    apply_reset(2);

    // Single read from the CPU port.
    drive(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 0, 0, gm, gd);
    chk("t1_gnt", gd, 0);
    chk("t1_p0_rvalid", bus.p0_rvalid, 1);
    chk("t1_p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
    chk("t1_p1_rvalid", bus.p1_rvalid, 0);

    // Continuous contention straight after reset.
    apply_reset(1);
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b00, 2'b00, 12'h040, 12'h041, 0, 0, gm, gd);
      chk("t2_contention", gd, (RR_EN != 0) ? (k % 2) : 0);
    end

    // Port 1 read-modify-write against a continuously requesting CPU.
    drive(2'b10, 2'b00, 2'b10, 12'h100, 12'h020, 0, 0, gm, gd);
    chk("t3_rmw_rd", gd, 1);
    chk("t3_busy_open", bus.busy, 1);
    drive(2'b11, 2'b10, 2'b00, 12'h100, 12'h020, 0, 32'h5, gm, gd);
    chk("t3_rmw_wr", gd, 1);
    chk("t3_busy_closed", bus.busy, 0);
    drive(2'b01, 2'b00, 2'b00, 12'h100, 12'h020, 0, 0, gm, gd);
    chk("t3_cpu", gd, 0);
    drive(2'b01, 2'b00, 2'b00, 12'h020, 12'h000, 0, 0, gm, gd);
    chk("t3_rmw_result", bus.p0_rdata, 32'h5);

    // Port 1 holds lock for 10 cycles while the CPU waits.
    for (int k = 1; k <= 10; k++) begin
      drive((k == 1) ? 2'b10 : 2'b11, 2'b00, 2'b10, 12'h060, 12'h050, 0, 0, gm, gd);
      if (k <= 5) chk("t4_lock_run", gd, (k == 5) ? 0 : 1);
      if (k == 6) chk("t4_after_expiry", gd, (RR_EN != 0) ? 1 : 0);
    end

    // Write by the CPU, immediate read of the same word by port 1.
    drive(2'b01, 2'b01, 2'b00, 12'h030, 12'h000, 32'h1234, 0, gm, gd);
    drive(2'b10, 2'b00, 2'b00, 12'h000, 12'h030, 0, 0, gm, gd);
    chk("t5_p1_rvalid", bus.p1_rvalid, 1);
    chk("t5_p1_rdata", bus.p1_rdata, 32'h1234);

    // Reset in the cycle after a granted read.
    drive(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 0, 0, gm, gd);
    chk("t6_rvalid_before", bus.p0_rvalid, 1);
    apply_reset(2);

    // Randomized traffic; a requester that is not granted holds its request.
    pv = 2'b00; pw = 2'b00; pl = 2'b00;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 9) < 6) begin
          pv[p] = 1'b1;
          pw[p] = ($urandom_range(0, 2) == 0);
          pa[p] = 12'($urandom_range(0, 15));
          pd[p] = $urandom;
          pl[p] = ($urandom_range(0, 2) == 0);
        end
      end
      drive(pv, pw, pl, pa[0], pa[1], pd[0], pd[1], gm, gd);
      if (gm >= 0) begin
        pv[gm] = 1'b0;
        if (pl[gm] && $urandom_range(0, 9) < 8) begin
          pv[gm] = 1'b1;
          pw[gm] = ($urandom_range(0, 3) == 0);
          pa[gm] = 12'($urandom_range(0, 15));
          pd[gm] = $urandom;
          pl[gm] = ($urandom_range(0, 4) != 0);
        end
      end
    end

    drive(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 0, gm, gd);
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
